serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 127 ++++++++++++
 tb/tb_serial_subtractor.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes diff = a - b one bit per clock, LSB first,
// through a single full-subtractor cell with a registered borrow. Operands are
// accepted on a valid/ready handshake and the result is held until consumed.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  // Counter must also hold WIDTH itself after the final increment.
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic [WIDTH-1:0]   r_sa;
  logic [WIDTH-1:0]   r_sb;
  logic [WIDTH-1:0]   r_res;
  logic               r_br;
  logic               r_a_msb;
  logic               r_b_msb;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_accept;
  logic               w_last;
  logic               w_d;
  logic               w_br_next;

  assign w_accept = in_valid & (r_state == S_IDLE);
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

  // One full-subtractor cell working on the current LSBs of the shift registers.
  assign w_d       = r_sa[0] ^ r_sb[0] ^ r_br;
  assign w_br_next = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_br);

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: IDLE -> RUN on handshake, RUN -> DONE on last bit,
  // DONE -> IDLE once the consumer takes the result.
  always_comb begin
    // NOTE: default assignment first so no path leaves the signal unassigned,
    // which would otherwise infer a latch.
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)  w_state_next = S_RUN;
      S_RUN:   if (w_last)    w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default:                w_state_next = S_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE:  in_ready  = 1'b1;
      S_RUN:   busy      = 1'b1;
      S_DONE:  out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // Datapath: load operands on handshake, then shift one bit per RUN edge.
  always_ff @(posedge clock) begin
    // NOTE: the datapath registers are reset too, because diff/borrow/overflow
    // are visible outputs that must read 0 straight after reset.
    if (reset) begin
      r_sa    <= '0;
      r_sb    <= '0;
      r_res   <= '0;
      r_br    <= 1'b0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_sa    <= a;
      r_sb    <= b;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      r_a_msb <= a[WIDTH-1];
      r_b_msb <= b[WIDTH-1];
    end else if (r_state == S_RUN) begin
      r_sa  <= r_sa >> 1;
      r_sb  <= r_sb >> 1;
      // Each new difference bit enters at the MSB; after WIDTH edges the
      // first-computed bit has reached position 0.
      r_res <= (r_res >> 1) | (WIDTH'(w_d) << (WIDTH - 1));
      r_br  <= w_br_next;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign diff   = r_res;
  assign borrow = r_br;
  // Signed overflow only possible when operand signs differ; it shows up as
  // a result whose sign disagrees with the minuend.
  assign overflow = (r_a_msb != r_b_msb) & (r_res[WIDTH-1] != r_a_msb);

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH = 4, 32 and 1.
// A driver issues operations and pushes model results into a scoreboard;
// an independent monitor pops and compares on every result handshake.
module tb_serial_subtractor;

  typedef struct {
    int          k;
    logic [31:0] diff;
    logic        borrow;
    logic        ovf;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;

  logic [31:0] a_v        [3];
  logic [31:0] b_v        [3];
  logic        in_valid_v [3];
  logic        out_ready_v[3];
  logic        in_ready_v [3];
  logic        out_valid_v[3];
  logic        busy_v     [3];
  logic        borrow_v   [3];
  logic        ovf_v      [3];
  logic [31:0] diff_v     [3];

  logic [3:0]  diff4;
  logic [31:0] diff32;
  logic [0:0]  diff1;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  serial_subtractor #(.WIDTH(4)) u_w4 (
    .clock(clock), .reset(reset), .a(a_v[0][3:0]), .b(b_v[0][3:0]),
    .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]), .diff(diff4),
    .borrow(borrow_v[0]), .overflow(ovf_v[0]), .out_valid(out_valid_v[0]),
    .out_ready(out_ready_v[0]), .busy(busy_v[0])
  );

  serial_subtractor #(.WIDTH(32)) u_w32 (
    .clock(clock), .reset(reset), .a(a_v[1]), .b(b_v[1]),
    .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]), .diff(diff32),
    .borrow(borrow_v[1]), .overflow(ovf_v[1]), .out_valid(out_valid_v[1]),
    .out_ready(out_ready_v[1]), .busy(busy_v[1])
  );

  serial_subtractor #(.WIDTH(1)) u_w1 (
    .clock(clock), .reset(reset), .a(a_v[2][0:0]), .b(b_v[2][0:0]),
    .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]), .diff(diff1),
    .borrow(borrow_v[2]), .overflow(ovf_v[2]), .out_valid(out_valid_v[2]),
    .out_ready(out_ready_v[2]), .busy(busy_v[2])
  );

  assign diff_v[0] = {28'd0, diff4};
  assign diff_v[1] = diff32;
  assign diff_v[2] = {31'd0, diff1};

  function automatic int wid(int k);
    case (k)
      0:       return 4;
      1:       return 32;
      default: return 1;
    endcase
  endfunction

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic exp_t model(int k, logic [31:0] a, logic [31:0] b);
    exp_t    e;
    int      w    = wid(k);
    longint  span = longint'(1) << w;
    longint  half = longint'(1) << (w - 1);
    longint  ua   = longint'(a) & (span - 1);
    longint  ub   = longint'(b) & (span - 1);
    longint  sa   = (ua >= half) ? ua - span : ua;
    longint  sbv  = (ub >= half) ? ub - span : ub;
    longint  res  = sa - sbv;
    e.k      = k;
    e.diff   = 32'((ua - ub + span) % span);
    e.borrow = (ua < ub);
    e.ovf    = (res > half - 1) || (res < -half);
    return e;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every result handshake must match the oldest expected entry.
  always @(negedge clock) begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (reset === 1'b0 && out_valid_v[k] === 1'b1 && out_ready_v[k] === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: instance %0d presented diff %0h with nothing pending", k, diff_v[k]);
        end else begin
          e = sb_q.pop_front();
          check("result_instance", 32'(k), 32'(e.k));
          check("diff", diff_v[k], e.diff);
          check("borrow", 32'(borrow_v[k]), 32'(e.borrow));
          check("overflow", 32'(ovf_v[k]), 32'(e.ovf));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One operation on instance k, optionally holding out_ready low for
  // 'stall' cycles once the result appears.
  task automatic run_op(int k, logic [31:0] a, logic [31:0] b, int stall);
    exp_t e;
    int   n;
    int   w = wid(k);
    e = model(k, a, b);
    a_v[k]        = a;
    b_v[k]        = b;
    in_valid_v[k] = 1'b1;
    n = 0;
    while (in_ready_v[k] !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("accept_wait", 32'(n < 50), 32'd1);
    sb_q.push_back(e);
    tick();
    // Operands changing after the handshake must not disturb the result.
    in_valid_v[k] = 1'b0;
    a_v[k]        = $urandom;
    b_v[k]        = $urandom;
    if (stall > 0) out_ready_v[k] = 1'b0;
    check("busy_in_run", 32'(busy_v[k]), 32'd1);
    check("in_ready_in_run", 32'(in_ready_v[k]), 32'd0);
    n = 1;
    while (out_valid_v[k] !== 1'b1 && n < w + 10) begin
      tick();
      n++;
    end
    check("latency", 32'(n), 32'(w + 1));
    for (int s = 0; s < stall; s++) begin
      in_valid_v[k] = 1'b1;
      a_v[k]        = $urandom;
      b_v[k]        = $urandom;
      check("stall_out_valid", 32'(out_valid_v[k]), 32'd1);
      check("stall_in_ready", 32'(in_ready_v[k]), 32'd0);
      check("stall_diff", diff_v[k], e.diff);
      check("stall_borrow", 32'(borrow_v[k]), 32'(e.borrow));
      tick();
    end
    in_valid_v[k]  = 1'b0;
    out_ready_v[k] = 1'b1;
    tick();
    check("idle_after_result", 32'(in_ready_v[k]), 32'd1);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      a_v[k]         = '0;
      b_v[k]         = '0;
      in_valid_v[k]  = 1'b0;
      out_ready_v[k] = 1'b1;
    end
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    for (int k = 0; k < 3; k++) begin
      check("rst_in_ready", 32'(in_ready_v[k]), 32'd1);
      check("rst_out_valid", 32'(out_valid_v[k]), 32'd0);
      check("rst_busy", 32'(busy_v[k]), 32'd0);
      check("rst_diff", diff_v[k], 32'd0);
      check("rst_borrow", 32'(borrow_v[k]), 32'd0);
      check("rst_overflow", 32'(ovf_v[k]), 32'd0);
    end

    // Directed 4-bit cases: plain, borrow, signed overflow both directions.
    run_op(0, 32'd5, 32'd3, 0);
    run_op(0, 32'd3, 32'd5, 0);
    run_op(0, 32'd8, 32'd1, 0);
    run_op(0, 32'd0, 32'd8, 0);

    // Backpressure for 10 cycles with in_valid pushing during DONE.
    run_op(0, 32'd6, 32'd9, 10);

    // Reset on the second RUN edge abandons the operation.
    a_v[0]        = 32'd9;
    b_v[0]        = 32'd2;
    in_valid_v[0] = 1'b1;
    tick();
    in_valid_v[0] = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_in_ready", 32'(in_ready_v[0]), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid_v[0]), 32'd0);
    check("mid_rst_busy", 32'(busy_v[0]), 32'd0);
    check("mid_rst_diff", diff_v[0], 32'd0);
    check("mid_rst_borrow", 32'(borrow_v[0]), 32'd0);
    check("mid_rst_overflow", 32'(ovf_v[0]), 32'd0);
    repeat (7) tick();
    run_op(0, 32'd7, 32'd7, 0);

    // Exhaustive sweeps at WIDTH=4 and WIDTH=1.
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        run_op(0, 32'(i), 32'(j), 0);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        run_op(2, 32'(i), 32'(j), (i == 1 && j == 0) ? 2 : 0);

    // WIDTH=32 corners then random pairs.
    run_op(1, 32'd0, 32'd1, 0);
    run_op(1, 32'h8000_0000, 32'd1, 0);
    run_op(1, 32'd0, 32'h8000_0000, 3);
    run_op(1, 32'h7fff_ffff, 32'hffff_ffff, 0);
    for (int i = 0; i < 1000; i++)
      run_op(1, $urandom, $urandom, 0);

    repeat (3) tick();
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
